// File: rtl/dcache_port_arbiter_pkg.sv
// Shared widths, the response-owner record and helpers for the dcache port arbiter.
package dcache_port_arbiter_pkg;

  localparam int D_ADDR_W         = 32;
  localparam int DATA_W           = 32;
  localparam int CACHE_DATA_W     = 64;
  localparam int BYTE_EN_W        = 4;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int OWNER_IDX_W      = 4;

  // Who owns the response that arrives one cycle after a grant.
  typedef struct packed {
    logic                   valid;
    logic                   is_store;
    logic [OWNER_IDX_W-1:0] ld_idx;
  } dcache_owner_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dcache_port_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping, as one-hot plus index.
module dcache_port_arbiter_rr_picker
  import dcache_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  always_comb begin
    int            j_int;
    logic [IDX_W-1:0] j;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    j_int = 0;
    j     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j_int = int'(ptr) + i;
      if (j_int >= NUM_REQ) j_int = j_int - NUM_REQ;
      j = IDX_W'(j_int);
      if (!valid && req[j]) begin
        valid    = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Arbitrates NUM_LD load FUs and the store queue onto one dcache port and
// routes the one-cycle-later response back to the owner.
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int NUM_LD       = 2,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_LD-1:0]                  ld_req,
  input  logic [NUM_LD*D_ADDR_W-1:0]         ld_addr,
  output logic [NUM_LD-1:0]                  ld_grant,
  input  logic                               st_req,
  input  logic [D_ADDR_W-1:0]                st_addr,
  input  logic [DATA_W-1:0]                  st_data,
  input  logic [BYTE_EN_W-1:0]               st_byte_en,
  output logic                               st_grant,
  input  logic                               squash,
  output logic                               dc_req_valid,
  output logic                               dc_req_write,
  output logic [D_ADDR_W-1:0]                dc_req_addr,
  output logic [DATA_W-1:0]                  dc_req_wdata,
  output logic [BYTE_EN_W-1:0]               dc_req_byte_en,
  input  logic                               dc_req_ready,
  input  logic                               dc_resp_valid,
  input  logic                               dc_resp_hit,
  input  logic [CACHE_DATA_W-1:0]            dc_resp_data,
  output logic [NUM_LD*(CACHE_DATA_W+1)-1:0] ld_resp,
  output logic                               st_done
);

  localparam int IDX_W  = idx_w(NUM_LD);
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam int RESP_W = CACHE_DATA_W + 1;

  logic [IDX_W-1:0]  rr_ptr;
  logic [CNT_W-1:0]  starve_cnt;
  dcache_owner_t     owner_p1;
  logic [NUM_LD-1:0] pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_vld;
  logic              starved, st_win, ld_win, vld_p0, resp_hit_p1;

  // Squash only hides loads from the picker; store priority still sees raw ld_req.
  dcache_port_arbiter_rr_picker #(
    .NUM_REQ (NUM_LD),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .req   (ld_req & {NUM_LD{~squash}}),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  // ---- p0: grant decision and request drive ----
  assign starved  = (starve_cnt >= CNT_W'(STARVE_LIMIT));
  assign st_win   = !reset && dc_req_ready && st_req && ((ld_req == '0) || starved);
  assign ld_win   = !reset && dc_req_ready && !st_win && pick_vld;
  assign vld_p0   = st_win | ld_win;
  assign st_grant = st_win;
  assign ld_grant = ld_win ? pick_grant : '0;

  assign dc_req_valid   = vld_p0;
  assign dc_req_write   = st_win;
  assign dc_req_wdata   = st_win ? st_data : '0;
  assign dc_req_byte_en = st_win ? st_byte_en : '0;

  always_comb begin
    dc_req_addr = st_win ? st_addr : '0;
    for (int i = 0; i < NUM_LD; i++) begin
      if (ld_grant[i]) dc_req_addr = ld_addr[i*D_ADDR_W +: D_ADDR_W];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr     <= '0;
      starve_cnt <= '0;
      owner_p1   <= '0;
    end else begin
      if (ld_win) rr_ptr <= (pick_idx == IDX_W'(NUM_LD - 1)) ? '0 : pick_idx + 1'b1;
      if (!st_req || st_win)  starve_cnt <= '0;
      else if (!starved)      starve_cnt <= starve_cnt + 1'b1;
      owner_p1.valid    <= vld_p0;
      owner_p1.is_store <= st_win;
      owner_p1.ld_idx   <= OWNER_IDX_W'(pick_idx);
    end
  end

  // ---- p1: response routing; a squash in this cycle kills a load's data ----
  assign resp_hit_p1 = !reset && owner_p1.valid && dc_resp_valid && dc_resp_hit &&
                       (owner_p1.is_store || !squash);
  assign st_done     = resp_hit_p1 && owner_p1.is_store;

  always_comb begin
    ld_resp = '0;
    for (int i = 0; i < NUM_LD; i++) begin
      if (resp_hit_p1 && !owner_p1.is_store && (owner_p1.ld_idx == OWNER_IDX_W'(i)))
        ld_resp[i*RESP_W +: RESP_W] = {1'b1, dc_resp_data};
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: grant checks each cycle, response
// expectations queued at grant time and consumed on the response cycle.
module tb_dcache_port_arbiter;

  localparam int NL = 2;
  localparam int RW = 65;

  logic            clock = 1'b0;
  logic            reset;
  logic [NL-1:0]   ld_req;
  logic [NL*32-1:0] ld_addr;
  logic [NL-1:0]   ld_grant;
  logic            st_req;
  logic [31:0]     st_addr;
  logic [31:0]     st_data;
  logic [3:0]      st_byte_en;
  logic            st_grant;
  logic            squash;
  logic            dc_req_valid, dc_req_write;
  logic [31:0]     dc_req_addr, dc_req_wdata;
  logic [3:0]      dc_req_byte_en;
  logic            dc_req_ready, dc_resp_valid, dc_resp_hit;
  logic [63:0]     dc_resp_data;
  logic [NL*RW-1:0] ld_resp;
  logic            st_done;

  typedef struct packed {
    logic v;
    logic s;
    logic idx;
  } own_t;

  own_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  dcache_port_arbiter #(.NUM_LD(NL), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset), .ld_req(ld_req), .ld_addr(ld_addr),
    .ld_grant(ld_grant), .st_req(st_req), .st_addr(st_addr), .st_data(st_data),
    .st_byte_en(st_byte_en), .st_grant(st_grant), .squash(squash),
    .dc_req_valid(dc_req_valid), .dc_req_write(dc_req_write),
    .dc_req_addr(dc_req_addr), .dc_req_wdata(dc_req_wdata),
    .dc_req_byte_en(dc_req_byte_en), .dc_req_ready(dc_req_ready),
    .dc_resp_valid(dc_resp_valid), .dc_resp_hit(dc_resp_hit),
    .dc_resp_data(dc_resp_data), .ld_resp(ld_resp), .st_done(st_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [NL*RW-1:0] obs, input logic [NL*RW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check just after.
  task automatic step(input string tag, input logic rst, input logic [1:0] lreq,
                      input logic sreq, input logic rdy, input logic sq,
                      input logic rv, input logic rh, input logic [63:0] rd,
                      input logic [1:0] e_lg, input logic e_sg);
    own_t             o;
    logic [NL*RW-1:0] e_resp;
    logic             e_done;
    logic [31:0]      e_addr;
    @(negedge clock);
    reset = rst; ld_req = lreq; st_req = sreq; dc_req_ready = rdy; squash = sq;
    dc_resp_valid = rv; dc_resp_hit = rh; dc_resp_data = rd;
    #2;
    e_addr = e_sg ? st_addr : (e_lg[0] ? ld_addr[31:0] : (e_lg[1] ? ld_addr[63:32] : 32'h0));
    chk({tag, ".ld_grant"}, NL*RW'(ld_grant), NL*RW'(e_lg));
    chk({tag, ".st_grant"}, NL*RW'(st_grant), NL*RW'(e_sg));
    chk({tag, ".req_valid"}, NL*RW'(dc_req_valid), NL*RW'(|{e_lg, e_sg}));
    chk({tag, ".req_write"}, NL*RW'(dc_req_write), NL*RW'(e_sg));
    chk({tag, ".req_addr"}, NL*RW'(dc_req_addr), NL*RW'(e_addr));
    chk({tag, ".req_wdata"}, NL*RW'(dc_req_wdata), NL*RW'(e_sg ? st_data : 32'h0));
    chk({tag, ".req_be"}, NL*RW'(dc_req_byte_en), NL*RW'(e_sg ? st_byte_en : 4'h0));
    e_resp = '0;
    e_done = 1'b0;
    if (q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s.queue: observed empty expected entry", tag);
    end else begin
      o = q.pop_front();
      if (!rst && o.v && rv && rh) begin
        if (o.s) e_done = 1'b1;
        else if (!sq) e_resp[o.idx*RW +: RW] = {1'b1, rd};
      end
    end
    chk({tag, ".ld_resp"}, ld_resp, e_resp);
    chk({tag, ".st_done"}, NL*RW'(st_done), NL*RW'(e_done));
    o.v = !rst && (|{e_lg, e_sg});
    o.s = e_sg;
    o.idx = e_lg[1];
    q.push_back(o);
  endtask

  localparam logic [63:0] HD = 64'hDEAD_BEEF_0000_1111;

  initial begin
    own_t z;
    z = '0;
    reset = 1'b1; ld_req = '0; st_req = 1'b0; squash = 1'b0; dc_req_ready = 1'b0;
    dc_resp_valid = 1'b0; dc_resp_hit = 1'b0; dc_resp_data = '0;
    ld_addr = {32'h0000_2000, 32'h0000_1000};
    st_addr = 32'h0000_3000; st_data = 32'hCAFE_F00D; st_byte_en = 4'hF;
    q.push_back(z);

    // Reset with everything active: outputs all zero.
    step("rst0", 1, 2'b11, 1, 1, 0, 1, 1, HD, 2'b00, 0);
    step("rst1", 1, 2'b11, 1, 1, 0, 1, 1, HD, 2'b00, 0);
    // First cycle after reset: response dropped, round-robin starts at 0.
    step("rr0", 0, 2'b11, 0, 1, 0, 1, 1, HD, 2'b01, 0);
    step("rr1", 0, 2'b11, 0, 1, 0, 1, 1, HD, 2'b10, 0);
    step("rr2", 0, 2'b00, 0, 1, 0, 1, 1, HD, 2'b00, 0);
    // Store starvation against a continuous load.
    step("stv1", 0, 2'b01, 1, 1, 0, 1, 1, 64'h1, 2'b01, 0);
    step("stv2", 0, 2'b01, 1, 1, 0, 1, 1, 64'h2, 2'b01, 0);
    step("stv3", 0, 2'b01, 1, 1, 0, 1, 1, 64'h3, 2'b01, 0);
    step("stv4", 0, 2'b01, 1, 1, 0, 1, 1, 64'h4, 2'b01, 0);
    step("stv5", 0, 2'b01, 1, 1, 0, 1, 1, 64'h5, 2'b00, 1);
    step("stv6", 0, 2'b01, 0, 1, 0, 1, 1, 64'h6, 2'b01, 0);
    chk("stv6.starve_cnt", NL*RW'(dut.starve_cnt), '0);
    // Port not ready: no grants, store counter saturates.
    step("nr1", 0, 2'b11, 1, 0, 0, 1, 1, 64'h7, 2'b00, 0);
    step("nr2", 0, 2'b11, 1, 0, 0, 0, 0, 64'h0, 2'b00, 0);
    step("nr3", 0, 2'b11, 1, 0, 0, 0, 0, 64'h0, 2'b00, 0);
    step("nr4", 0, 2'b11, 1, 0, 0, 0, 0, 64'h0, 2'b00, 0);
    step("nr5", 0, 2'b11, 1, 0, 0, 0, 0, 64'h0, 2'b00, 0);
    step("nrgo", 0, 2'b11, 1, 1, 0, 0, 0, 64'h0, 2'b00, 1);
    chk("nrgo.starve_cnt", NL*RW'(dut.starve_cnt), NL*RW'(4));
    // Squash drops a load response and blocks loads but spares stores.
    step("sq0", 0, 2'b10, 0, 1, 0, 1, 1, 64'h8, 2'b10, 0);
    step("sq1", 0, 2'b11, 0, 1, 1, 1, 1, HD, 2'b00, 0);
    step("sq2", 0, 2'b00, 1, 1, 1, 0, 0, 64'h0, 2'b00, 1);
    step("sq3", 0, 2'b00, 0, 1, 1, 1, 1, HD, 2'b00, 0);
    // Miss then retry then hit.
    step("ms0", 0, 2'b01, 0, 1, 0, 0, 0, 64'h0, 2'b01, 0);
    step("ms1", 0, 2'b01, 0, 1, 0, 1, 0, HD, 2'b01, 0);
    step("ms2", 0, 2'b00, 0, 1, 0, 1, 1, 64'h9, 2'b00, 0);
    // Reset with an owner in flight.
    step("rr3", 0, 2'b10, 0, 1, 0, 0, 0, 64'h0, 2'b10, 0);
    step("rr4", 1, 2'b11, 1, 1, 0, 1, 1, HD, 2'b00, 0);
    step("rr5", 0, 2'b11, 0, 1, 0, 1, 1, HD, 2'b01, 0);
    step("rr6", 0, 2'b00, 0, 1, 0, 1, 1, 64'hA, 2'b00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
